multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Moore FSM that sequences the multi-cycle MIPS datapath: shared memory, IR, PC, ALU and register file.
- Supported instructions: R-type, lw, sw, beq, addi and j.
- Decodes the 6-bit opcode from the instruction register.
- Drives every datapath mux/enable once per state, and stalls on a memory-ready handshake.

Parameters:
- MEM_WAIT_EN, 1, when 1 the memory states hold until MemReady=1; when 0 MemReady is ignored (treated as 1).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  synchronous active-low reset.
- Opcode  in  6  IR[31:26], sampled in DECODE.
- MemReady  in  1  memory access completes this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU Zero (beq).
- IorD  out  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  IR load.
- MemtoReg  out  1  write-back data: 0=ALUOut, 1=MDR.
- RegDst  out  1  write-back register: 0=rt, 1=rd.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A input: 0=PC, 1=A.
- ALUSrcB  out  2  ALU B input: 00=B, 01=4, 10=signext imm, 11=signext imm<<2.
- ALUOp  out  2  00=add, 01=sub, 10=funct-decoded.
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- IllegalOp  out  1  sticky flag, set on an unsupported opcode.
- State  out  4  current state encoding, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Codes 12-15 go to FETCH next cycle, and all outputs are 0 in them.
- Reset:
  - While Rst_n=0 at a rising edge: State<=FETCH and IllegalOp<=0.
  - While Rst_n is low, all control outputs are forced to 0 combinationally.
  - Reset asserted mid-instruction abandons it; no partial write occurs after the reset edge.
- Outputs are a pure function of State (plus MemReady gating noted below). Every output not listed for a state is 0.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute).
  - Next state by Opcode: 000000->EXEC, 100011 or 101011->MEMADR, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP.
  - Any other opcode: IllegalOp<=1, next state FETCH (treated as a nop).
- MEMADR:
  - Drives ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state MEMRD if Opcode=100011, else MEMWR.
- MEMRD: MemRead=1, IorD=1. Holds until MemReady, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next state FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until MemReady, then goes to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next state FETCH.
- JUMP: PCWrite=1, PCSource=10. Next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Next state FETCH.
- Latency with no memory stalls:
  - R-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq and j: 3 cycles.
  - addi: 4 cycles.
  - Each cycle MemReady is low in FETCH/MEMRD/MEMWR adds one cycle.
- MemWrite and RegWrite are never asserted in the same cycle.
- Opcode changes outside DECODE/MEMADR have no effect.
- IllegalOp clears only on reset.

Test Plan:
- Reset: hold Rst_n=0 for 3 cycles, then release with MemReady=1 -> all outputs 0 during reset; State=0 with MemRead=1, IRWrite=1, PCWrite=1 on the first cycle after release.
- lw, Opcode=6'b100011, MemReady=1 -> State sequence 0,1,2,3,4,0; RegWrite=1, MemtoReg=1 only in state 4.
- sw, Opcode=6'b101011, MemReady held 0 for 2 cycles in MEMWR -> State 0,1,2,5,5,5,0; MemWrite=1 for 3 cycles; RegWrite never 1.
- beq 6'b000100 -> State 0,1,8,0, with PCWriteCond=1, ALUOp=01, PCSource=01 in state 8. j 6'b000010 -> State 0,1,9,0, with PCWrite=1, PCSource=10 in state 9.
- R-type 6'b000000 then addi 6'b001000 -> RegDst=1 in RWB (state 7); RegDst=0 in ADDIWB (state 11); 4 cycles each.
- Illegal opcode 6'b111111 -> State 0,1,0; IllegalOp=1 from the cycle after DECODE and stays set until reset. Assert Rst_n=0 while in MEMRD -> State=0 next edge, MemRead=0 while reset is held.

Source files
------------

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath (R-type, lw, sw, beq, addi, j).
// Memory states stall on MemReady; unsupported opcodes set a sticky IllegalOp flag.
module multicycle_control #(
    parameter int MEM_WAIT_EN = 1
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       IllegalOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state, next_state;
    logic   mem_rdy;
    logic   illegal_dec;

    assign mem_rdy = (MEM_WAIT_EN != 0) ? MemReady : 1'b1;
    assign State   = state;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state     <= S_FETCH;
            IllegalOp <= 1'b0;
        end else begin
            state <= next_state;
            if (illegal_dec) IllegalOp <= 1'b1;
        end
    end

    always_comb begin
        next_state  = S_FETCH;
        illegal_dec = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        case (state)
            S_FETCH: begin
                MemRead    = 1'b1;
                ALUSrcB    = 2'b01;
                IRWrite    = mem_rdy;
                PCWrite    = mem_rdy;
                next_state = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JUMP;
                    default: begin
                        illegal_dec = 1'b1;
                        next_state  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead    = 1'b1;
                IorD       = 1'b1;
                next_state = mem_rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                next_state = mem_rdy ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b10;
                next_state = S_RWB;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            default: ;
        endcase
        // Reset overrides everything so no write can slip out while it is held.
        if (!Rst_n) begin
            illegal_dec = 1'b0;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
            PCSource    = 2'b00;
        end
    end

endmodule
